// File: rtl/maincont_fsm.sv
// maincont_fsm: multicycle main control for the MIPS-subset datapath.
// Moore FSM with registered outputs; write strobes are additionally gated by
// rst_n so that no write can occur while reset is held.
// Optional feature macro: MAINCONT_NORI_EN (adds the nori NORIEX/NORIWB path).
module maincont_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       balrzSigCont,
   output logic       aluop1,
   output logic       aluop0,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic [1:0] brtype,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BEQ    = 4'd8,
      BLTZ   = 4'd9,
      JUMP   = 4'd12,
      BALRZ  = 4'd13
`ifdef MAINCONT_NORI_EN
      ,
      NORIEX = 4'd10,
      NORIWB = 4'd11
`endif
   } state_t;

   typedef struct packed {
      logic       aluop1;
      logic       aluop0;
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] regdst;
      logic [1:0] alusrcb;
      logic [1:0] pcsource;
      logic [1:0] brtype;
      logic       instr_done;
      logic       in_decode;
   } ctl_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BLTZ = 6'b000001;
   localparam logic [5:0] OP_NORI = 6'b011000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t state, nxt;
   ctl_t   ctl;
   logic   is_sw;
   logic   op_legal;

   // Per-state output values; the registered copy is loaded with the
   // value for the state being entered, so outputs track the state exactly.
   function automatic ctl_t state_outputs(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.memread = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
         DECODE: begin c.alusrcb = 2'b11; c.in_decode = 1'b1; end
         MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
         MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1; end
         MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; c.instr_done = 1'b1; end
         EXEC:   begin c.alusrca = 1'b1; c.aluop1 = 1'b1; end
         RWB:    begin c.regwrite = 1'b1; c.regdst = 2'b01; c.instr_done = 1'b1; end
         BEQ, BLTZ: begin
            c.alusrca = 1'b1; c.aluop0 = 1'b1; c.pcwritecond = 1'b1;
            c.pcsource = 2'b01; c.instr_done = 1'b1;
            c.brtype = (s == BEQ) ? 2'b01 : 2'b10;
         end
`ifdef MAINCONT_NORI_EN
         NORIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop1 = 1'b1; c.aluop0 = 1'b1; end
         NORIWB: begin c.regwrite = 1'b1; c.instr_done = 1'b1; end
`endif
         JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; c.instr_done = 1'b1; end
         BALRZ:  begin
            c.regwrite = 1'b1; c.regdst = 2'b10; c.pcwritecond = 1'b1;
            c.pcsource = 2'b11; c.brtype = 2'b11; c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Opcode legality as seen in DECODE.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_R, OP_BEQ, OP_BLTZ, OP_J: op_legal = 1'b1;
`ifdef MAINCONT_NORI_EN
         OP_NORI: op_legal = 1'b1;
`endif
         default: op_legal = 1'b0;
      endcase
   end

   // Next-state selection; unused encodings fall back to FETCH.
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:  nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_R:         nxt = EXEC;
               OP_BEQ:       nxt = BEQ;
               OP_BLTZ:      nxt = BLTZ;
`ifdef MAINCONT_NORI_EN
               OP_NORI:      nxt = NORIEX;
`endif
               OP_J:         nxt = JUMP;
               default:      nxt = FETCH;
            endcase
         end
         // lw/sw choice uses the opcode captured when leaving DECODE
         MEMADR: nxt = is_sw ? MEMWR : MEMRD;
         MEMRD:  nxt = MEMWB;
         EXEC:   nxt = balrzSigCont ? BALRZ : RWB;
`ifdef MAINCONT_NORI_EN
         NORIEX: nxt = NORIWB;
`endif
         default: nxt = FETCH;
      endcase
   end

   // State, registered outputs and captured store flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         ctl   <= state_outputs(FETCH);
         is_sw <= 1'b0;
      end else begin
         state <= nxt;
         ctl   <= state_outputs(nxt);
         if (state == DECODE)
            is_sw <= (op == OP_SW);
      end
   end

   assign aluop1      = ctl.aluop1;
   assign aluop0      = ctl.aluop0;
   assign pcwrite     = ctl.pcwrite     & rst_n;
   assign pcwritecond = ctl.pcwritecond & rst_n;
   assign iord        = ctl.iord;
   assign memread     = ctl.memread     & rst_n;
   assign memwrite    = ctl.memwrite    & rst_n;
   assign irwrite     = ctl.irwrite     & rst_n;
   assign memtoreg    = ctl.memtoreg;
   assign regwrite    = ctl.regwrite    & rst_n;
   assign alusrca     = ctl.alusrca;
   assign regdst      = ctl.regdst;
   assign alusrcb     = ctl.alusrcb;
   assign pcsource    = ctl.pcsource;
   assign brtype      = ctl.brtype;
   assign instr_done  = ctl.instr_done;
   assign illegal     = ctl.in_decode & ~op_legal & rst_n;

endmodule

// File: doc/maincont_fsm.md
# maincont_fsm

Multicycle main control unit for the MIPS-subset datapath. It is a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and the `aluop1`/`aluop0` pair consumed by the downstream ALU control block. It takes back that block's `balrzSigCont` to run the `balrz` link/branch step.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  6  opcode, `IR[31:26]`; valid from the DECODE state onward
- `balrzSigCont`  in  1  R-type `balrz` flag from the ALU control block; sampled in EXEC
- `aluop1`, `aluop0`  out  1 each  ALU operation class:
  - 00 = add
  - 01 = sub/branch
  - 10 = R-type
  - 11 = nori
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `memtoreg`, `regwrite`, `alusrca`  out  1 each  datapath strobes and selects
- `regdst`  out  2  write-register select:
  - 00 = rt
  - 01 = rd
  - 10 = $31
- `alusrcb`  out  2  ALU B source:
  - 00 = reg
  - 01 = 4
  - 10 = sign-extended immediate
  - 11 = sign-extended immediate << 2
- `pcsource`  out  2  PC source:
  - 00 = ALU
  - 01 = ALUOut
  - 10 = jump target
  - 11 = rs
- `brtype`  out  2  branch condition select:
  - 00 = none
  - 01 = zero (beq)
  - 10 = negative (bltz)
  - 11 = zero with link (balrz)
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- State register: 4 bits. All outputs decode from the state only (Moore).
- Defaults: every output is 0 in every state unless listed below.
- States and the outputs asserted in each:
  - FETCH: `memread`, `irwrite`, `alusrcb`=01, `pcwrite`.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`, `alusrcb`=10.
  - MEMRD: `memread`, `iord`.
  - MEMWB: `regwrite`, `memtoreg`, `regdst`=00, `instr_done`.
  - MEMWR: `memwrite`, `iord`, `instr_done`.
  - EXEC: `alusrca`, `aluop1`=1.
  - RWB: `regwrite`, `regdst`=01, `instr_done`.
  - BEQ: `alusrca`, `aluop0`=1, `pcwritecond`, `pcsource`=01, `brtype`=01, `instr_done`.
  - BLTZ: same outputs as BEQ, but `brtype`=10.
  - NORIEX: `alusrca`, `alusrcb`=10, `aluop1`=`aluop0`=1.
  - NORIWB: `regwrite`, `regdst`=00, `instr_done`.
  - JUMP: `pcwrite`, `pcsource`=10, `instr_done`.
  - BALRZ: `regwrite`, `regdst`=10, `pcwritecond`, `pcsource`=11, `brtype`=11, `instr_done`.
  - The datapath writes PC+4 in the BALRZ link write.
- Transitions:
  - FETCH→DECODE, unconditionally.
  - DECODE branches on `op`:
    - 100011 (lw) or 101011 (sw)→MEMADR
    - 000000→EXEC
    - 000100→BEQ
    - 000001→BLTZ
    - 011000 (nori)→NORIEX
    - 000010→JUMP
    - any other value→FETCH, with `illegal`=1 in DECODE
  - MEMADR→MEMRD for lw; MEMADR→MEMWR for sw.
  - MEMRD→MEMWB.
  - EXEC→BALRZ if `balrzSigCont`=1, else EXEC→RWB.
  - NORIEX→NORIWB.
  - MEMWB, MEMWR, RWB, BEQ, BLTZ, NORIWB, JUMP and BALRZ→FETCH.
- `illegal` and `instr_done` never assert in the same cycle.
- Unused state encodings→FETCH on the next edge.

## Timing
- Cycles per instruction, FETCH through the last state:
  - lw 5
  - sw 4
  - R-type 4
  - balrz 4
  - nori 4
  - beq 3
  - bltz 3
  - j 3
  - illegal 2
- `op` and `balrzSigCont` are sampled at the rising edge that leaves DECODE and EXEC respectively. They must be stable during those states.
- Reset, while `rst_n`=0:
  - The state is forced to FETCH asynchronously.
  - `pcwrite`, `pcwritecond`, `memread`, `memwrite`, `irwrite` and `regwrite` are forced to 0 combinationally. No write may occur during reset.
  - `alusrcb`=01; every other output is 0.
- The first FETCH strobes appear in the cycle after `rst_n` rises.
- Reset asserted mid-instruction abandons that instruction immediately. No partial writeback occurs after the reset edge.

## Configuration
- `MAINCONT_NORI_EN` defined: opcode 011000 follows DECODE→NORIEX→NORIWB→FETCH, and `aluop`=11 is reachable.
- `MAINCONT_NORI_EN` undefined:
  - Opcode 011000 is treated as illegal: DECODE→FETCH with the `illegal` pulse.
  - NORIEX and NORIWB are not synthesised.
  - `aluop`=11 is never produced.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random `op` → all write strobes 0 and `alusrcb`=01. Release → `memread`=`irwrite`=`pcwrite`=1 in the first cycle.
- lw then sw: `op`=100011 → state order FETCH, DECODE, MEMADR, MEMRD, MEMWB, with `regwrite`=`memtoreg`=1 in cycle 5. Then `op`=101011 → `memwrite`=`iord`=1 in cycle 4, and `regwrite` never 1.
- R-type then balrz: `op`=0 with `balrzSigCont`=0 → RWB with `regdst`=01. Repeat with `balrzSigCont`=1 → BALRZ with `regdst`=10, `pcsource`=11, `brtype`=11.
- Branches and jump:
  - beq → `aluop`=01, `pcwritecond`=1, `brtype`=01 in cycle 3.
  - bltz → `brtype`=10 in cycle 3.
  - j → `pcwrite`=1, `pcsource`=10 in cycle 3.
  - Each is followed by FETCH.
- nori and illegal: `op`=011000 → `aluop`=11 in NORIEX when the macro is defined; `illegal` pulse with return to FETCH after 2 cycles when it is undefined. `op`=111111 → `illegal` pulse in both builds.
- Reset mid-lw: drop `rst_n` during MEMRD → FETCH immediately, and `regwrite` never asserts for that instruction.
